// File: rtl/uart_gcd_system.sv
// UART-fed GCD engine: two received bytes are reduced by repeated subtraction
// and the result is sent back over UART, shown on the LEDs and on 7-segment digits.
module uart_gcd_system #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  output logic [7:0] led,
  input  logic [7:0] switch,
  output logic [6:0] digi_out1,
  output logic [6:0] digi_out2,
  output logic [6:0] digi_out3,
  output logic [6:0] digi_out4
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] ST_WAIT_A  = 2'd0;
  localparam logic [1:0] ST_WAIT_B  = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_SEND    = 2'd3;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid;

  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;
  logic          tx_start, tx_busy;

  logic [1:0]    st_q, st_d;
  logic [7:0]    a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
  logic [7:0]    res_q, res_d, led_q, led_d;
  logic          sent_q, sent_d;

  logic          unused_switch;
  assign unused_switch = &switch[7:1];

  // Start needs a high-to-low transition, so a line stuck low cannot retrigger.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else rx_idx_d = rx_idx_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_valid   = rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    st_d     = st_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    led_d    = led_q;
    sent_d   = sent_q;
    tx_start = 1'b0;
    case (st_q)
      ST_WAIT_A: begin
        if (rx_valid) begin
          a_d  = rx_shift_q;
          st_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (rx_valid) begin
          b_d  = rx_shift_q;
          x_d  = a_q;
          y_d  = rx_shift_q;
          st_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (x_q == 8'd0 || y_q == 8'd0 || x_q == y_q) begin
          res_d = x_q | y_q;
          led_d = x_q | y_q;
          st_d  = ST_SEND;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: begin
        if (!sent_q) begin
          tx_start = 1'b1;
          sent_d   = 1'b1;
        end else if (!tx_busy) begin
          sent_d = 1'b0;
          st_d   = ST_WAIT_A;
        end
      end
    endcase
  end

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d    = 1'b1;
        tx_cnt_d = '0;
        if (tx_start) begin
          tx_shift_d = res_q;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      st_q       <= ST_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      res_q      <= '0;
      led_q      <= '0;
      sent_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      st_q       <= st_d;
      a_q        <= a_d;
      b_q        <= b_d;
      x_q        <= x_d;
      y_q        <= y_d;
      res_q      <= res_d;
      led_q      <= led_d;
      sent_q     <= sent_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    digi_out1 = hex7(a_q[7:4]);
    digi_out2 = hex7(a_q[3:0]);
    digi_out3 = switch[0] ? hex7(res_q[7:4]) : hex7(b_q[7:4]);
    digi_out4 = switch[0] ? hex7(res_q[3:0]) : hex7(b_q[3:0]);
  end

  assign txd = txd_q;
  assign led = led_q;

endmodule

// File: tb/tb_uart_gcd_system.sv
// Drives UART byte pairs into uart_gcd_system and compares the returned frame,
// LEDs and digits against a Euclid-based reference.
module tb_uart_gcd_system;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;
  logic [7:0] led;
  logic [7:0] sw = 8'h00;
  logic [6:0] d1, d2, d3, d4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] txq[$];

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  uart_gcd_system #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk(clk), .reset(rst_n), .rxd(rxd), .txd(txd), .led(led), .switch(sw),
    .digi_out1(d1), .digi_out2(d2), .digi_out3(d3), .digi_out4(d4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    int unsigned p = a;
    int unsigned q = b;
    int unsigned t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p[7:0];
  endfunction

  // Independent serial decoder: samples each bit at its centre.
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(posedge clk); #1;
      if (rst_n && txd === 1'b0) begin
        repeat (CPB/2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = txd;
        end
        repeat (CPB) @(posedge clk);
        #1;
        txq.push_back({txd, b});
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop);
    rxd = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = v[i];
      hold(CPB);
    end
    rxd = stop;
    hold(CPB);
    rxd = 1'b1;
    hold(stop ? 2 : 2*CPB);
  endtask

  task automatic wait_tx(input logic [7:0] exp);
    int n = 0;
    logic [8:0] f;
    while (txq.size() == 0 && n < 256 + 30*CPB) begin
      hold(1);
      n++;
    end
    check("tx_frame_seen", (txq.size() > 0), 1);
    if (txq.size() > 0) begin
      f = txq.pop_front();
      check("tx_byte", f[7:0], exp);
      check("tx_stop", f[8], 1);
    end
    hold(CPB);
  endtask

  task automatic check_disp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    sw = 8'hFE;
    #1;
    check("dig1_a_hi", d1, font[a[7:4]]);
    check("dig2_a_lo", d2, font[a[3:0]]);
    check("dig3_b_hi", d3, font[b[7:4]]);
    check("dig4_b_lo", d4, font[b[3:0]]);
    sw = 8'h01;
    #1;
    check("dig3_r_hi", d3, font[r[7:4]]);
    check("dig4_r_lo", d4, font[r[3:0]]);
    sw = 8'h00;
    #1;
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] g = gcd_ref(a, b);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
    wait_tx(g);
    check("led", led, g);
    check_disp(a, b, g);
  endtask

  initial begin : main
    logic [7:0] a, b;
    int n;
    hold(5);
    check("rst_txd", txd, 1);
    check("rst_led", led, 0);
    check("rst_d1", d1, 7'b1000000);
    check("rst_d2", d2, 7'b1000000);
    check("rst_d3", d3, 7'b1000000);
    check("rst_d4", d4, 7'b1000000);
    rst_n = 1'b1;
    hold(4);

    run_pair(8'h96, 8'hB9);

    send_byte(8'h1E, 1'b1);
    hold(4*CPB);
    check("no_tx_single", txq.size(), 0);
    check("led_hold", led, 8'h05);
    check("single_d1", d1, font[1]);
    check("single_d2", d2, font[14]);
    send_byte(8'h2D, 1'b1);
    wait_tx(gcd_ref(8'h1E, 8'h2D));
    check_disp(8'h1E, 8'h2D, gcd_ref(8'h1E, 8'h2D));

    run_pair(8'h00, 8'h2A);
    run_pair(8'h00, 8'h00);
    run_pair(8'hFF, 8'h01);
    run_pair(8'h2A, 8'h00);

    for (int k = 0; k < 10; k++) begin
      int unsigned m = $urandom_range(0, 4);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (m == 0) a = 8'h00;
      if (m == 1) b = a;
      run_pair(a, b);
    end

    rxd = 1'b0;
    hold(CPB/4);
    rxd = 1'b1;
    hold(3*CPB);
    run_pair(8'h24, 8'h36);

    send_byte(8'h24, 1'b1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h36, 1'b1);
    wait_tx(8'h12);
    check_disp(8'h24, 8'h36, 8'h12);

    rxd = 1'b0;
    hold(25*CPB);
    check("held_low_no_tx", txq.size(), 0);
    rxd = 1'b1;
    hold(2*CPB);
    run_pair(8'h48, 8'h30);

    send_byte(8'h30, 1'b1);
    send_byte(8'h4B, 1'b1);
    n = 0;
    while (txd !== 1'b0 && n < 600) begin
      hold(1);
      n++;
    end
    check("tx_started", txd, 0);
    hold(3*CPB);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_txd", txd, 1);
    check("mid_rst_led", led, 0);
    check("mid_rst_d1", d1, 7'b1000000);
    check("mid_rst_d2", d2, 7'b1000000);
    check("mid_rst_d3", d3, 7'b1000000);
    check("mid_rst_d4", d4, 7'b1000000);
    hold(2);
    rst_n = 1'b1;
    hold(12*CPB);
    txq.delete();
    run_pair(8'h0C, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
